pc_sel_unit: RTL and testbench
==============================

# pc_sel_unit

Parametrised next-PC unit for the fetch stage; successor to the two-input PC/direction select. Holds the program counter register and selects each cycle between sequential, branch, jump, return and exception targets under a fixed priority. A circular return-address stack (RAS) supplies return targets. Drives instruction memory address and the fetch pipeline register.

## Interface
- ADDR_W, 32, address width in bits
- INC, 4, sequential increment (bytes per instruction)
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)
- RESET_VEC, 0, PC value after reset
- EXC_VEC, 32'h80, exception entry address
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC and RAS; ignore all requests except exc
- exc  in  1  exception request
- branch_taken  in  1  conditional branch resolved taken
- branch_dir  in  ADDR_W  branch target
- jump  in  1  unconditional jump
- jump_dir  in  ADDR_W  jump target
- call  in  1  qualifies jump as call: push pc+INC
- ret  in  1  return request
- pc  out  ADDR_W  current program counter
- src_sel  out  3  source used for the last PC update (package encoding)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- ras_err  out  1  sticky: underflow or overwrite occurred

## Operation
- Priority, highest first: reset > exc > stall > ret > jump > branch_taken > sequential.
- reset: pc=RESET_VEC, src_sel=SRC_RST, RAS count=0, pointer=0, ras_err=0.
- exc: pc=EXC_VEC, src_sel=SRC_EXC; RAS unchanged; overrides stall.
- stall (no exc): pc, src_sel, RAS all hold.
- ret: pc=RAS top, pop (count-1). If call also asserted with jump: pc=top, top replaced by pc+INC, count unchanged.
- ret on empty RAS: pc=pc+INC, src_sel=SRC_SEQ, ras_err set, count stays 0.
- jump: pc=jump_dir, src_sel=SRC_JMP; if call, push pc+INC.
- push when full: overwrite oldest entry (circular wrap), count stays RAS_DEPTH, ras_err set.
- call without jump: ignored.
- branch_taken: pc=branch_dir, src_sel=SRC_BR.
- otherwise pc=pc+INC, modulo 2^ADDR_W (wrap at top of address space, no flag).
- Targets are not alignment-checked.

## Timing
- pc is registered; a request sampled at edge N is reflected in pc after edge N; no combinational path from inputs to pc.
- ras_empty/ras_full are decoded from registered count; valid same cycle as pc.
- ras_err clears only on reset.
- Reset mid-stall or mid-return fully reinitialises; no pending state survives.

## Configuration
- PC_SEL_RAS_EN defined: RAS as described.
- Not defined: no stack storage; ret loads pc=jump_dir with src_sel=SRC_RET; call ignored; ras_empty=1, ras_full=0, ras_err=0 constant.

## Structure
- pc_sel_pkg: SRC_RST=0, SRC_SEQ=1, SRC_BR=2, SRC_JMP=3, SRC_RET=4, SRC_EXC=5 localparams and the 3-bit source width.
- Sub-module ras_stack (parameters ADDR_W, RAS_DEPTH): push/pop/replace, top, count, full/empty, err; instantiated only under PC_SEL_RAS_EN.

## Test plan
- Reset then 3 idle cycles -> pc 0x0, 0x4, 0x8, 0xC; src_sel=SRC_SEQ.
- branch_taken with branch_dir=0x100 and jump with jump_dir=0x200 same cycle -> pc=0x200, src_sel=SRC_JMP.
- At pc=0x10, jump+call to 0x40; then ret -> pc=0x40 then 0x14; ras_empty returns to 1.
- Five calls with RAS_DEPTH=4, then five rets -> four correct returns newest-first, fifth ret gives pc+4, ras_err=1.
- stall high with jump to 0x300 and exc asserted together -> pc=0x80; next cycle stall alone holds 0x80.
- pc=0xFFFFFFFC sequential -> pc=0x0; reset during ras_full -> pc=RESET_VEC, ras_empty=1, ras_err=0.

Source files
------------

// File: rtl/pc_sel_pkg.sv
// Shared encodings for the next-PC unit: the source-select codes reported on src_sel.
// Feature macro used by this slice: PC_SEL_RAS_EN (return-address stack).
package pc_sel_pkg;

   localparam int unsigned SRC_W = 3;

   localparam logic [SRC_W-1:0] SRC_RST = 3'd0;
   localparam logic [SRC_W-1:0] SRC_SEQ = 3'd1;
   localparam logic [SRC_W-1:0] SRC_BR  = 3'd2;
   localparam logic [SRC_W-1:0] SRC_JMP = 3'd3;
   localparam logic [SRC_W-1:0] SRC_RET = 3'd4;
   localparam logic [SRC_W-1:0] SRC_EXC = 3'd5;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop or replace-top per cycle, with sticky error flag.
// Only instantiated when PC_SEL_RAS_EN is defined.
module ras_stack #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              replace,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              err
);

   localparam int unsigned   PTR_W    = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  top_idx;
   logic [PTR_W:0]    count;

   // ptr is the next free slot; once full it also addresses the oldest entry,
   // so a push while full overwrites exactly that one.
   assign top_idx = ptr - PTR_W'(1);
   assign top     = mem[top_idx];
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (full) err   <= 1'b1;
         else      count <= count + 1'b1;
      end else if (pop) begin
         if (empty) begin
            err <= 1'b1;
         end else begin
            ptr   <= top_idx;
            count <= count - 1'b1;
         end
      end else if (replace && empty) begin
         err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (push)                   mem[ptr]     <= push_data;
         else if (replace && !empty) mem[top_idx] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sel_unit.sv
// Fetch-stage next-PC unit: PC register plus fixed-priority target select.
// Define PC_SEL_RAS_EN to add the return-address stack; otherwise ret takes jump_dir.
module pc_sel_unit
   import pc_sel_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       INC       = 4,
   parameter int unsigned       RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] EXC_VEC   = 'h80
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              exc,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_dir,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_dir,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc,
   output logic [SRC_W-1:0]  src_sel,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_err
);

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_nxt;
   logic [SRC_W-1:0]  src_nxt;

   assign pc_inc = pc + ADDR_W'(INC);

`ifdef PC_SEL_RAS_EN
   logic [ADDR_W-1:0] ras_top;
   logic              stk_push;
   logic              stk_pop;
   logic              stk_replace;

   ras_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (stk_push),
      .pop       (stk_pop),
      .replace   (stk_replace),
      .push_data (pc_inc),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .err       (ras_err)
   );
`else
   logic unused_ras_cfg;

   assign unused_ras_cfg = call ^ (RAS_DEPTH == 0);
   assign ras_empty      = 1'b1;
   assign ras_full       = 1'b0;
   assign ras_err        = 1'b0;
`endif

   always_comb begin
      pc_nxt  = pc;
      src_nxt = src_sel;
`ifdef PC_SEL_RAS_EN
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_replace = 1'b0;
`endif
      if (exc) begin
         pc_nxt  = EXC_VEC;
         src_nxt = SRC_EXC;
      end else if (stall) begin
         pc_nxt  = pc;
         src_nxt = src_sel;
      end else if (ret) begin
`ifdef PC_SEL_RAS_EN
         if (ras_empty) begin
            // Underflow: fall through sequentially; the pop flags the error.
            pc_nxt  = pc_inc;
            src_nxt = SRC_SEQ;
            stk_pop = 1'b1;
         end else begin
            pc_nxt  = ras_top;
            src_nxt = SRC_RET;
            if (jump && call) stk_replace = 1'b1;
            else              stk_pop     = 1'b1;
         end
`else
         pc_nxt  = jump_dir;
         src_nxt = SRC_RET;
`endif
      end else if (jump) begin
         pc_nxt  = jump_dir;
         src_nxt = SRC_JMP;
`ifdef PC_SEL_RAS_EN
         stk_push = call;
`endif
      end else if (branch_taken) begin
         pc_nxt  = branch_dir;
         src_nxt = SRC_BR;
      end else begin
         pc_nxt  = pc_inc;
         src_nxt = SRC_SEQ;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_VEC;
         src_sel <= SRC_RST;
      end else begin
         pc      <= pc_nxt;
         src_sel <= src_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sel_unit.sv
// Directed bench for pc_sel_unit; RAS checks are selected by PC_SEL_RAS_EN.
module tb_pc_sel_unit;
   import pc_sel_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        exc;
   logic        branch_taken;
   logic [31:0] branch_dir;
   logic        jump;
   logic [31:0] jump_dir;
   logic        call;
   logic        ret;
   logic [31:0] pc;
   logic [2:0]  src_sel;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_err;

   int n_cmp = 0;
   int n_bad = 0;

   pc_sel_unit dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .exc          (exc),
      .branch_taken (branch_taken),
      .branch_dir   (branch_dir),
      .jump         (jump),
      .jump_dir     (jump_dir),
      .call         (call),
      .ret          (ret),
      .pc           (pc),
      .src_sel      (src_sel),
      .ras_empty    (ras_empty),
      .ras_full     (ras_full),
      .ras_err      (ras_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   // checking task
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic idle_in();
      reset = 0; stall = 0; exc = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
      branch_dir = '0; jump_dir = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle_in();
   endtask

   task automatic do_jump(input logic [31:0] tgt, input logic is_call);
      jump = 1; call = is_call; jump_dir = tgt;
      tick();
   endtask

   task automatic do_ret();
      ret = 1;
      tick();
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
   endtask

   task automatic chk_pc(input string tag, input logic [31:0] epc, input logic [2:0] esrc);
      chk({tag, ".pc"}, pc, epc);
      chk({tag, ".src"}, {29'd0, src_sel}, {29'd0, esrc});
   endtask

   task automatic chk_ras(input string tag, input logic e, input logic f, input logic r);
      chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, e});
      chk({tag, ".full"},  {31'd0, ras_full},  {31'd0, f});
      chk({tag, ".err"},   {31'd0, ras_err},   {31'd0, r});
   endtask

   initial begin
      idle_in();
      @(negedge clk);
      do_reset();
      chk_pc("rst", 32'h0, SRC_RST);
      chk_ras("rst", 1, 0, 0);

      for (int i = 1; i <= 3; i++) begin
         tick();
         chk_pc($sformatf("seq%0d", i), 32'(i * 4), SRC_SEQ);
      end

      branch_taken = 1; branch_dir = 32'h100; jump = 1; jump_dir = 32'h200;
      tick();
      chk_pc("jmp_over_br", 32'h200, SRC_JMP);
      branch_taken = 1; branch_dir = 32'h100;
      tick();
      chk_pc("br", 32'h100, SRC_BR);

      do_jump(32'h10, 0);
      chk_pc("jmp10", 32'h10, SRC_JMP);
      do_jump(32'h40, 1);
      chk_pc("call40", 32'h40, SRC_JMP);
`ifdef PC_SEL_RAS_EN
      chk_ras("call40", 0, 0, 0);
      do_ret();
      chk_pc("ret14", 32'h14, SRC_RET);
      chk_ras("ret14", 1, 0, 0);

      // five nested calls into a four-deep stack
      for (int i = 1; i <= 5; i++) begin
         do_jump(32'(i * 32'h1000), 1);
         chk_pc($sformatf("call%0d", i), 32'(i * 32'h1000), SRC_JMP);
      end
      chk_ras("ovf", 0, 1, 1);
      for (int i = 4; i >= 1; i--) begin
         do_ret();
         chk_pc($sformatf("pop%0d", i), 32'(i * 32'h1000 + 4), SRC_RET);
      end
      chk_ras("drained", 1, 0, 1);
      do_ret();
      chk_pc("underflow", 32'h1008, SRC_SEQ);
      chk_ras("underflow", 1, 0, 1);

      // ret+jump+call swaps the top entry in place
      do_reset();
      chk_ras("rst2", 1, 0, 0);
      do_jump(32'h40, 1);
      jump = 1; call = 1; ret = 1; jump_dir = 32'h900;
      tick();
      chk_pc("replace", 32'h4, SRC_RET);
      chk_ras("replace", 0, 0, 0);
      do_ret();
      chk_pc("ret_repl", 32'h44, SRC_RET);
      chk_ras("ret_repl", 1, 0, 0);
      do_ret();
      chk_pc("udf_empty", 32'h48, SRC_SEQ);
      chk_ras("udf_empty", 1, 0, 1);
`else
      chk_ras("call40", 1, 0, 0);
      ret = 1; jump_dir = 32'h700;
      tick();
      chk_pc("ret_dir", 32'h700, SRC_RET);
      ret = 1; jump = 1; call = 1; jump_dir = 32'h740;
      tick();
      chk_pc("ret_call", 32'h740, SRC_RET);
      chk_ras("ret_call", 1, 0, 0);
`endif

      stall = 1; jump = 1; jump_dir = 32'h300; exc = 1;
      tick();
      chk_pc("exc_stall", 32'h80, SRC_EXC);
      stall = 1;
      tick();
      chk_pc("stall", 32'h80, SRC_EXC);
      stall = 1; ret = 1; branch_taken = 1; branch_dir = 32'h500;
      tick();
      chk_pc("stall_req", 32'h80, SRC_EXC);
      tick();
      chk_pc("unstall", 32'h84, SRC_SEQ);

      do_jump(32'hFFFF_FFFC, 0);
      tick();
      chk_pc("wrap", 32'h0, SRC_SEQ);

`ifdef PC_SEL_RAS_EN
      for (int i = 1; i <= 5; i++) do_jump(32'(i * 32'h100), 1);
      chk_ras("full2", 0, 1, 1);
`endif
      stall = 1; reset = 1;
      tick();
      chk_pc("rst_full", 32'h0, SRC_RST);
      chk_ras("rst_full", 1, 0, 0);
      tick();
      chk_pc("after_rst", 32'h4, SRC_SEQ);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
